// File: rtl/esn7e_demo_system_sysid_arbiter.sv
// esn7e_demo_system_sysid_arbiter
// Two-requester read arbiter in front of a zero-wait sysid control slave.
// Each accepted read walks IDLE -> ACCESS -> RESP. The read data returns
// two cycles after acceptance, and at most one read completes every three cycles.
//
// Ports:
//   clock, reset_n         single clock, asynchronous active-low reset
//   mX_read, mX_address    requester X read strobe and word address
//   mX_waitrequest         low only in the cycle requester X is accepted
//   mX_readdata            last captured slave word (shared register)
//   mX_readdatavalid       one-cycle pulse in RESP for the granted requester
//   s_address, s_readdata  shared slave address out / combinational data in
//   grant_count0/1         saturating per-requester acceptance counters
module esn7e_demo_system_sysid_arbiter #(
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              m0_read,
  input  logic              m0_address,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic              m1_read,
  input  logic              m1_address,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              s_address,
  input  logic [DATA_W-1:0] s_readdata,
  output logic [15:0]       grant_count0,
  output logic [15:0]       grant_count1
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last;     // 1 = m1 was granted most recently
  logic                r_addr;
  logic                r_id;       // 0 = m0 owns the transaction, 1 = m1
  logic [DATA_W-1:0]   r_rdata;
  logic [15:0]         r_gcnt0;
  logic [15:0]         r_gcnt1;
  logic [15:0]         w_gcnt0_nxt;
  logic [15:0]         w_gcnt1_nxt;
  logic                w_accept;
  logic                w_win;      // winning requester id, valid with w_accept

  // Winner select. In round-robin mode a tie goes to the requester that was
  // not granted last; a lone requester always wins.
  always_comb begin
    w_win = 1'b0;
    if (PRIO_MODE == 1) begin
      w_win = !m0_read;
    end else if (m0_read && m1_read) begin
      w_win = !r_last;
    end else begin
      w_win = !m0_read;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (m0_read || m1_read) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Counters are rewritten every cycle from their next-value terms so the
  // register always tracks exactly what the saturating adder produced.
  always_comb begin
    w_gcnt0_nxt = r_gcnt0;
    w_gcnt1_nxt = r_gcnt1;
    if (w_accept && !w_win && (r_gcnt0 != 16'hFFFF)) begin
      w_gcnt0_nxt = r_gcnt0 + 16'd1;
    end
    if (w_accept && w_win && (r_gcnt1 != 16'hFFFF)) begin
      w_gcnt1_nxt = r_gcnt1 + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_addr  <= 1'b0;
      r_id    <= 1'b0;
      r_rdata <= '0;
      r_gcnt0 <= 16'd0;
      r_gcnt1 <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_gcnt0 <= w_gcnt0_nxt;
      r_gcnt1 <= w_gcnt1_nxt;
      if (w_accept) begin
        r_addr <= w_win ? m1_address : m0_address;
        r_id   <= w_win;
        r_last <= w_win;
      end
      if (r_state == ST_ACCESS) begin
        r_rdata <= s_readdata;
      end
    end
  end

  // Waitrequest drops only for the winner in its acceptance cycle; it is
  // high otherwise, including whenever the read strobe itself is low.
  assign m0_waitrequest   = !(w_accept && !w_win);
  assign m1_waitrequest   = !(w_accept && w_win);
  assign s_address        = (r_state == ST_ACCESS) ? r_addr : 1'b0;
  assign m0_readdata      = r_rdata;
  assign m1_readdata      = r_rdata;
  assign m0_readdatavalid = (r_state == ST_RESP) && !r_id;
  assign m1_readdatavalid = (r_state == ST_RESP) && r_id;
  assign grant_count0     = r_gcnt0;
  assign grant_count1     = r_gcnt1;

endmodule

// File: tb/tb_esn7e_demo_system_sysid_arbiter.sv
// Directed bench for esn7e_demo_system_sysid_arbiter. Two instances share the
// requester inputs: dut0 runs round-robin, dut1 fixed priority. Each has its
// own behavioural sysid slave (addr 0 -> 0, addr 1 -> 0x57A2E960).
module tb_esn7e_demo_system_sysid_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;
  logic m0_read, m0_address, m1_read, m1_address;

  logic        a_wait0, a_wait1, a_rdv0, a_rdv1, a_saddr;
  logic [31:0] a_rdata0, a_rdata1, a_srd;
  logic [15:0] a_gc0, a_gc1;
  logic        b_wait0, b_wait1, b_rdv0, b_rdv1, b_saddr;
  logic [31:0] b_rdata0, b_rdata1, b_srd;
  logic [15:0] b_gc0, b_gc1;

  assign a_srd = a_saddr ? 32'h57A2E960 : 32'h0000_0000;
  assign b_srd = b_saddr ? 32'h57A2E960 : 32'h0000_0000;

  esn7e_demo_system_sysid_arbiter #(.DATA_W(32), .PRIO_MODE(0)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .m0_read(m0_read), .m0_address(m0_address), .m0_waitrequest(a_wait0),
    .m0_readdata(a_rdata0), .m0_readdatavalid(a_rdv0),
    .m1_read(m1_read), .m1_address(m1_address), .m1_waitrequest(a_wait1),
    .m1_readdata(a_rdata1), .m1_readdatavalid(a_rdv1),
    .s_address(a_saddr), .s_readdata(a_srd),
    .grant_count0(a_gc0), .grant_count1(a_gc1)
  );

  esn7e_demo_system_sysid_arbiter #(.DATA_W(32), .PRIO_MODE(1)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .m0_read(m0_read), .m0_address(m0_address), .m0_waitrequest(b_wait0),
    .m0_readdata(b_rdata0), .m0_readdatavalid(b_rdv0),
    .m1_read(m1_read), .m1_address(m1_address), .m1_waitrequest(b_wait1),
    .m1_readdata(b_rdata1), .m1_readdatavalid(b_rdv1),
    .s_address(b_saddr), .s_readdata(b_srd),
    .grant_count0(b_gc0), .grant_count1(b_gc1)
  );

  int checks   = 0;
  int failures = 0;
  logic ev;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Lone m0 read of address 1 on dut0; entered and left in IDLE just after a negedge.
  task automatic read_m0();
    m0_read = 1'b1; m0_address = 1'b1;
    #1 chk1("rd_wait0_T", a_wait0, 1'b0);
    @(negedge clock); m0_read = 1'b0;
    #1 chk1("rd_saddr_T1", a_saddr, 1'b1);
    @(negedge clock);
    #1 chk1("rd_rdv0_T2", a_rdv0, 1'b1);
    chk32("rd_data_T2", a_rdata0, 32'h57A2E960);
    @(negedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; m0_read = 1'b0; m0_address = 1'b0;
    m1_read = 1'b0; m1_address = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk1("rst_wait0", a_wait0, 1'b1);
    chk1("rst_wait1", a_wait1, 1'b1);
    chk1("rst_rdv0", a_rdv0, 1'b0);
    chk1("rst_rdv1", a_rdv1, 1'b0);
    chk1("rst_saddr", a_saddr, 1'b0);
    chk32("rst_rdata", a_rdata0, 32'h0);
    chk16("rst_gc0", a_gc0, 16'h0);
    chk16("rst_gc1", a_gc1, 16'h0);

    // Lone m0 read of address 1, acceptance on the first edge after reset.
    @(negedge clock); reset_n = 1'b1;
    m0_read = 1'b1; m0_address = 1'b1;
    #1 chk1("s32_wait0_T", a_wait0, 1'b0);
    chk1("s32_wait1_T", a_wait1, 1'b1);
    @(negedge clock); m0_read = 1'b0;
    #1 chk1("s32_saddr_T1", a_saddr, 1'b1);
    chk1("s32_rdv0_T1", a_rdv0, 1'b0);
    @(negedge clock);
    #1 chk1("s32_rdv0_T2", a_rdv0, 1'b1);
    chk32("s32_data_T2", a_rdata0, 32'h57A2E960);
    chk1("s32_rdv1_T2", a_rdv1, 1'b0);
    chk16("s32_gc0", a_gc0, 16'd1);
    chk1("s32_saddr_T2", a_saddr, 1'b0);
    @(negedge clock);
    #1 chk1("s32_rdv0_T3", a_rdv0, 1'b0);
    chk32("s32_hold", a_rdata0, 32'h57A2E960);

    // m1 reads address 0 after the address-1 read.
    m1_read = 1'b1; m1_address = 1'b0;
    #1 chk1("s37_wait1_T", a_wait1, 1'b0);
    @(negedge clock); m1_read = 1'b0;
    #1 chk1("s37_saddr_T1", a_saddr, 1'b0);
    @(negedge clock);
    #1 chk1("s37_rdv1", a_rdv1, 1'b1);
    chk32("s37_data1", a_rdata1, 32'h0);
    chk1("s37_rdv0", a_rdv0, 1'b0);
    chk16("s37_gc1", a_gc1, 16'd1);
    @(negedge clock);
    #1;

    // Both requesters continuously high from reset: dut0 alternates, dut1 favours m0.
    reset_n = 1'b0;
    m0_read = 1'b1; m0_address = 1'b1;
    m1_read = 1'b1; m1_address = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      ev = (g % 2 == 0);
      chk1("s33_wait0_idle", a_wait0, !ev);
      chk1("s33_wait1_idle", a_wait1, ev);
      chk1("s34_wait0_idle", b_wait0, 1'b0);
      chk1("s34_wait1_idle", b_wait1, 1'b1);
      @(negedge clock);
      #1 chk1("s33_wait0_acc", a_wait0, 1'b1);
      chk1("s33_wait1_acc", a_wait1, 1'b1);
      chk1("s33_saddr_acc", a_saddr, ev);
      chk1("s34_saddr_acc", b_saddr, 1'b1);
      @(negedge clock);
      #1 chk1("s33_rdv0", a_rdv0, ev);
      chk1("s33_rdv1", a_rdv1, !ev);
      chk32("s33_data", a_rdata0, ev ? 32'h57A2E960 : 32'h0);
      chk1("s33_wait0_resp", a_wait0, 1'b1);
      chk1("s33_wait1_resp", a_wait1, 1'b1);
      chk1("s34_rdv0", b_rdv0, 1'b1);
      chk1("s34_rdv1", b_rdv1, 1'b0);
      chk1("s34_wait1_resp", b_wait1, 1'b1);
      @(negedge clock);
      #1;
    end
    m0_read = 1'b0; m1_read = 1'b0;
    #1 chk16("s33_gc0", a_gc0, 16'd2);
    chk16("s33_gc1", a_gc1, 16'd2);
    chk16("s34_gc0", b_gc0, 16'd4);
    chk16("s34_gc1", b_gc1, 16'd0);

    // Reset pulsed during ACCESS aborts the read.
    @(negedge clock);
    m0_read = 1'b1; m0_address = 1'b1;
    #1 chk1("s35_wait0_T", a_wait0, 1'b0);
    @(negedge clock); m0_read = 1'b0; reset_n = 1'b0;
    #1 chk1("s35_saddr_rst", a_saddr, 1'b0);
    chk16("s35_gc0_rst", a_gc0, 16'd0);
    chk16("s35_gc1_rst", a_gc1, 16'd0);
    chk32("s35_rdata_rst", a_rdata0, 32'h0);
    chk1("s35_rdv0_rst", a_rdv0, 1'b0);
    @(negedge clock); reset_n = 1'b1;
    #1 chk1("s35_rdv0_a", a_rdv0, 1'b0);
    chk1("s35_rdv1_a", a_rdv1, 1'b0);
    @(negedge clock);
    #1 chk1("s35_rdv0_b", a_rdv0, 1'b0);
    chk1("s35_rdv1_b", a_rdv1, 1'b0);
    chk32("s35_rdata_b", a_rdata0, 32'h0);
    read_m0();
    chk16("s35_gc0_after", a_gc0, 16'd1);

    // Counter saturation: preload just below full, then keep reading.
    @(negedge clock);
    force dut0.r_gcnt0 = 16'hFFFE;
    @(negedge clock);
    release dut0.r_gcnt0;
    #1 chk16("s36_preload", a_gc0, 16'hFFFE);
    read_m0();
    chk16("s36_full", a_gc0, 16'hFFFF);
    read_m0();
    chk16("s36_sat1", a_gc0, 16'hFFFF);
    read_m0();
    chk16("s36_sat2", a_gc0, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/esn7e_demo_system_sysid_arbiter.md
ESN7E_DEMO_SYSTEM_SYSID_ARBITER -- requirements
Module: esn7e_demo_system_sysid_arbiter

Parameters
REQ-001 SHALL have parameter DATA_W, default 32, width of the sysid read data word.
REQ-002 SHALL have parameter PRIO_MODE, default 0, arbitration mode: 0 = round-robin, 1 = fixed priority with m0 highest.

Interface
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 m0_read  input  1  requester 0 read request.
REQ-006 m0_address  input  1  requester 0 word address (0 = ID word, 1 = timestamp word).
REQ-007 m0_waitrequest  output  1  requester 0 stall; request not accepted while high.
REQ-008 m0_readdata  output  DATA_W  requester 0 returned data.
REQ-009 m0_readdatavalid  output  1  one-cycle pulse qualifying m0_readdata.
REQ-010 m1_read, m1_address, m1_waitrequest, m1_readdata, m1_readdatavalid SHALL mirror REQ-005..REQ-009 for requester 1.
REQ-011 s_address  output  1  address driven to the shared sysid control slave.
REQ-012 s_readdata  input  DATA_W  combinational (zero-wait) read data from the sysid slave.
REQ-013 grant_count0, grant_count1  output  16 each  saturating count of accepted reads per requester.

Function
REQ-014 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, one cycle per non-IDLE state.
REQ-015 IDLE: if any mX_read high, SHALL select a winner, drop the winner's waitrequest low in that same cycle (combinational), latch its address and id, go to ACCESS; otherwise stay IDLE.
REQ-016 A requester that is not the winner, or any requester while the FSM is in ACCESS or RESP, SHALL see waitrequest = 1 whenever its read is high.
REQ-017 waitrequest SHALL be 1 whenever the corresponding read is 0 (idle-high).
REQ-018 ACCESS: s_address SHALL equal the latched address; s_readdata SHALL be captured into the response register at the end of the cycle.
REQ-019 RESP: the winner's readdatavalid SHALL be 1 for exactly this cycle with readdata equal to the captured word; the other requester's readdatavalid SHALL be 0.
REQ-020 Latency: acceptance at cycle T -> readdatavalid at T+2; maximum throughput one read per 3 cycles.
REQ-021 s_address SHALL be 0 in IDLE and RESP.
REQ-022 mX_readdata SHALL hold the last captured word between responses (both ports driven from one register).
REQ-023 PRIO_MODE=0: with both reads high, the winner SHALL be the requester not granted last; a single requester SHALL win immediately regardless of history.
REQ-024 PRIO_MODE=1: m0 SHALL win whenever m0_read is high.
REQ-025 The last-grant register SHALL update only on acceptance.
REQ-026 grant_countX SHALL increment by 1 on each acceptance of requester X and hold at 0xFFFF (no wrap).
REQ-027 The arbiter SHALL not store requests: a read deasserted before acceptance is simply not serviced.
REQ-028 A requester's read asserted during RESP SHALL be eligible in the following IDLE cycle, never earlier.

Reset
REQ-029 On reset_n low, asynchronously: FSM = IDLE, last-grant = m1 (so m0 wins the first tie), response register = 0, grant counters = 0, all readdatavalid = 0, s_address = 0.
REQ-030 Reset asserted in ACCESS or RESP SHALL abort the transaction; no readdatavalid SHALL be issued for it after reset release.
REQ-031 The first acceptance SHALL be possible in the first clock edge after reset_n rises.

Verification
REQ-032 m0 reads addr 1 alone, slave returns 0x57A2E960 at addr 1 -> m0_waitrequest 0 at T, s_address 1 at T+1, m0_readdatavalid with 0x57A2E960 at T+2, grant_count0 = 1.
REQ-033 Both read continuously from reset, PRIO_MODE=0 -> grants alternate m0, m1, m0, m1 at T, T+3, T+6, T+9; each gets exactly one readdatavalid per grant.
REQ-034 Same stimulus, PRIO_MODE=1 -> m0 granted every 3 cycles; m1 waitrequest stays 1, grant_count1 = 0.
REQ-035 reset_n pulsed low during ACCESS -> no readdatavalid on either port; all outputs at reset values; next request serviced normally at latency 2.
REQ-036 grant_count0 preloaded via 65535 m0 reads, then 2 more -> grant_count0 = 0xFFFF, no wrap.
REQ-037 m1 reads addr 0 (slave returns 0) after an addr-1 read -> m1_readdata 0x00000000 with m1_readdatavalid; m0_readdatavalid stays 0.
